ls_proc_param: RTL and testbench

//  Parametrised multi-cycle load-store processor; next generation of the 4-bit core.

---
 rtl/ls_proc_param_if.sv | 28 ++
 rtl/ls_proc_param.sv | 170 +++++++++++++++++
 tb/tb_ls_proc_param.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_proc_param_if.sv
// Instruction-memory req/ack port of the ls_proc_param core.
// The master side is the core and the slave side is the instruction memory.
interface ls_proc_param_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PC_W   = 4
);
  localparam int unsigned INSTR_W = 3 + ADDR_W + DATA_W;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ls_proc_param.sv
// Parametrised multi-cycle load-store core: req/ack fetch, internal data RAM, ALU with flags.
// Optional feature macro BRANCH_EN turns opcode 000 into BZ (branch to {op1,op2} when zero set).
module ls_proc_param #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PC_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run,
  ls_proc_param_if.master        imem,
  input  logic [ADDR_W-1:0]      i_dbg_addr,
  output logic [DATA_W-1:0]      o_dbg_data,
  output logic [PC_W-1:0]        o_pc,
  output logic                   o_carry,
  output logic                   o_zero,
  output logic                   o_busy,
  output logic                   o_halted
);

  localparam int unsigned INSTR_W = 3 + ADDR_W + DATA_W;
  localparam int unsigned Depth   = 1 << ADDR_W;

  typedef enum logic [2:0] {
    OpNop  = 3'b000,
    OpLdi  = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpAnd  = 3'b100,
    OpOr   = 3'b101,
    OpXor  = 3'b110,
    OpHalt = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StRead,
    StExec,
    StWrite,
    StHalt
  } state_e;

  state_e               r_state;
  state_e               w_state_d;
  logic [PC_W-1:0]      r_pc;
  logic [INSTR_W-1:0]   r_instr;
  logic                 r_carry;
  logic                 r_zero;
  logic [DATA_W-1:0]    r_opa;
  logic [DATA_W-1:0]    r_res;
  logic                 r_res_carry;
  logic [DATA_W-1:0]    r_mem [Depth];

  opcode_e              w_opcode;
  logic [ADDR_W-1:0]    w_op1;
  logic [DATA_W-1:0]    w_op2;
  logic                 w_is_ldi;
  logic                 w_is_alu;
  logic [DATA_W:0]      w_alu_sum;
  logic [DATA_W-1:0]    w_alu_res;
  logic                 w_alu_carry;
  logic [PC_W-1:0]      w_pc_next;

  assign w_opcode = opcode_e'(r_instr[INSTR_W-1 -: 3]);
  assign w_op1    = r_instr[DATA_W +: ADDR_W];
  assign w_op2    = r_instr[DATA_W-1:0];
  assign w_is_ldi = (w_opcode == OpLdi);
  assign w_is_alu = (w_opcode != OpNop) && (w_opcode != OpLdi) && (w_opcode != OpHalt);

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (i_run) w_state_d = StFetch;
      StFetch:  if (imem.imem_ack) w_state_d = StDecode;
      StDecode: begin
        unique case (w_opcode)
          OpNop, OpLdi: w_state_d = StWrite;
          OpHalt:       w_state_d = StHalt;
          default:      w_state_d = StRead;
        endcase
      end
      StRead:   w_state_d = StExec;
      StExec:   w_state_d = StWrite;
      StWrite:  w_state_d = StFetch;
      StHalt:   w_state_d = StHalt;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // ALU: one extra result bit carries the carry-out, or the borrow for SUB.
  always_comb begin
    w_alu_sum = '0;
    unique case (w_opcode)
      OpAdd:   w_alu_sum = {1'b0, r_opa} + {1'b0, w_op2};
      OpSub:   w_alu_sum = {1'b0, r_opa} - {1'b0, w_op2};
      OpAnd:   w_alu_sum = {1'b0, r_opa & w_op2};
      OpOr:    w_alu_sum = {1'b0, r_opa | w_op2};
      OpXor:   w_alu_sum = {1'b0, r_opa ^ w_op2};
      default: w_alu_sum = '0;
    endcase
  end

  assign w_alu_res   = w_alu_sum[DATA_W-1:0];
  assign w_alu_carry = w_alu_sum[DATA_W];

`ifdef BRANCH_EN
  logic [PC_W-1:0] w_target;
  assign w_target  = PC_W'(r_instr[ADDR_W+DATA_W-1:0]);
  assign w_pc_next = ((w_opcode == OpNop) && r_zero) ? w_target : r_pc + PC_W'(1);
`else
  assign w_pc_next = r_pc + PC_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= '0;
      r_instr     <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_opa       <= '0;
      r_res       <= '0;
      r_res_carry <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if ((r_state == StFetch) && imem.imem_ack) begin
        r_instr <= imem.imem_rdata;
      end
      if (r_state == StRead) begin
        r_opa <= r_mem[w_op1];
      end
      if (r_state == StExec) begin
        r_res       <= w_alu_res;
        r_res_carry <= w_alu_carry;
      end
      if (r_state == StWrite) begin
        if (w_is_ldi) begin
          r_mem[w_op1] <= w_op2;
        end else if (w_is_alu) begin
          r_mem[w_op1] <= r_res;
          r_carry      <= r_res_carry;
          r_zero       <= (r_res == '0);
        end
        r_pc <= w_pc_next;
      end
    end
  end

  assign imem.imem_req  = (r_state == StFetch);
  assign imem.imem_addr = r_pc;
  assign o_dbg_data     = r_mem[i_dbg_addr];
  assign o_pc           = r_pc;
  assign o_carry        = r_carry;
  assign o_zero         = r_zero;
  assign o_busy         = (r_state != StIdle) && (r_state != StHalt);
  assign o_halted       = (r_state == StHalt);

endmodule

// File: tb/tb_ls_proc_param.sv
// Bench for ls_proc_param: directed programs plus random instructions against an ISA-level model.
module tb_ls_proc_param;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int PW = 4;
  localparam int IW = 3 + AW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [PW-1:0] pc;
  logic          carry;
  logic          zero;
  logic          busy;
  logic          halted;

  ls_proc_param_if #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW)) bus ();

  ls_proc_param #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_run      (run),
    .imem       (bus),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .o_pc       (pc),
    .o_carry    (carry),
    .o_zero     (zero),
    .o_busy     (busy),
    .o_halted   (halted)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Architectural model: RAM contents, pc and flags as plain integers.
  int m_mem [16];
  int m_pc;
  int m_c;
  int m_z;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input int op, input int a, input int b);
    logic [2:0] o3;
    logic [3:0] a4;
    logic [3:0] b4;
    o3 = op[2:0];
    a4 = a[3:0];
    b4 = b[3:0];
    return {o3, a4, b4};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_pc = 0;
    m_c  = 0;
    m_z  = 0;
  endtask

  // Returns FETCH-to-FETCH latency (FETCH-to-HALT for HALT) with ack in the same cycle.
  task automatic model_exec(input logic [IW-1:0] ins, output int lat);
    int op;
    int a;
    int b;
    int s;
    op = int'(ins[10:8]);
    a  = int'(ins[7:4]);
    b  = int'(ins[3:0]);
    lat = 5;
    case (op)
      0: begin
        lat = 3;
`ifdef BRANCH_EN
        if (m_z == 1) m_pc = (a * 16 + b) % 16;
        else m_pc = (m_pc + 1) % 16;
`else
        m_pc = (m_pc + 1) % 16;
`endif
      end
      1: begin
        lat = 3;
        m_mem[a] = b;
        m_pc = (m_pc + 1) % 16;
      end
      7: lat = 2;
      default: begin
        case (op)
          2: begin
            s = m_mem[a] + b;
            m_c = (s > 15) ? 1 : 0;
            m_mem[a] = s % 16;
          end
          3: begin
            m_c = (m_mem[a] < b) ? 1 : 0;
            m_mem[a] = (m_mem[a] - b + 16) % 16;
          end
          4: begin m_mem[a] = m_mem[a] & b; m_c = 0; end
          5: begin m_mem[a] = m_mem[a] | b; m_c = 0; end
          default: begin m_mem[a] = m_mem[a] ^ b; m_c = 0; end
        endcase
        m_z = (m_mem[a] == 0) ? 1 : 0;
        m_pc = (m_pc + 1) % 16;
      end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic start();
    run = 1'b1;
    step();
    run = 1'b0;
    check("req_after_run", bus.imem_req, 1);
  endtask

  // Serve one fetch (ack after ack_delay cycles), let it retire, compare with the model.
  task automatic exec(input logic [IW-1:0] ins, input int ack_delay, input bit noise);
    int lat;
    int cyc;
    int a;
    int a2;
    a = int'(ins[7:4]);
    check("fetch_req", bus.imem_req, 1);
    check("fetch_addr", bus.imem_addr, m_pc);
    bus.imem_rdata = ins;
    bus.imem_ack   = 1'b0;
    for (int d = 0; d < ack_delay; d++) begin
      step();
      check("wait_req", bus.imem_req, 1);
      check("wait_addr", bus.imem_addr, m_pc);
    end
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = IW'($urandom);
    cyc = 1;
    while (!bus.imem_req && !halted && cyc < 20) begin
      if (noise) bus.imem_ack = $urandom_range(0, 1) == 1;
      step();
      cyc++;
    end
    bus.imem_ack = 1'b0;
    model_exec(ins, lat);
    check("latency", cyc, lat);
    check("pc", pc, m_pc);
    check("carry", carry, m_c);
    check("zero", zero, m_z);
    dbg_addr = a[AW-1:0];
    #1;
    check("dbg_op1", dbg_data, m_mem[a]);
    a2 = $urandom_range(0, 15);
    dbg_addr = a2[AW-1:0];
    #1;
    check("dbg_rand", dbg_data, m_mem[a2]);
  endtask

  initial begin
    reset          = 1'b1;
    run            = 1'b0;
    dbg_addr       = '0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    do_reset();

    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_carry", carry, 0);
    check("rst_zero", zero, 0);
    check("rst_req", bus.imem_req, 0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = AW'(i);
      #1;
      check("rst_ram", dbg_data, 0);
    end

    // First fetch held off four cycles, then LDI M[3]=9.
    start();
    exec(mk(1, 3, 9), 4, 1'b0);
    // LDI M[2]=F; ADD +1 wraps with carry and zero.
    exec(mk(1, 2, 15), 0, 1'b0);
    exec(mk(2, 2, 1), 0, 1'b0);
    // SUB borrow, then XOR to zero.
    exec(mk(1, 5, 2), 0, 1'b0);
    exec(mk(3, 5, 3), 0, 1'b0);
    exec(mk(6, 5, 15), 1, 1'b0);

    // Random non-HALT instructions, random ack delay, ack noise outside FETCH, run toggling.
    for (int n = 0; n < 60; n++) begin
      run = $urandom_range(0, 1) == 1;
      exec(mk($urandom_range(0, 6), $urandom_range(0, 15), $urandom_range(0, 15)),
           $urandom_range(0, 2), 1'b1);
    end
    run = 1'b0;

    // Sixteen NOPs wrap pc back to 0, then HALT at address 0.
    do_reset();
    start();
    for (int n = 0; n < 16; n++) exec(mk(0, n, n), 0, 1'b0);
    check("wrap_pc", pc, 0);
    exec(mk(7, 0, 0), 0, 1'b0);
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    run = 1'b1;
    step();
    step();
    step();
    run = 1'b0;
    check("halt_stays", halted, 1);
    check("halt_req", bus.imem_req, 0);
    check("halt_pc", pc, 0);

    // Reset during EXEC of ADD M[1]: no write, back to IDLE.
    do_reset();
    start();
    bus.imem_rdata = mk(2, 1, 5);
    bus.imem_ack   = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    step();
    step();
    check("exec_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    dbg_addr = AW'(1);
    #1;
    check("abort_ram", dbg_data, 0);
    check("abort_busy", busy, 0);
    check("abort_halted", halted, 0);
    check("abort_pc", pc, 0);
    step();
    check("abort_idle_req", bus.imem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
